program_loader: RTL and testbench

//   Writer side of instruction memory: receives a program as a byte stream, packs bytes into
//   32-bit words and writes them to consecutive word addresses of cpumemory before execution.

---
 rtl/program_loader_if.sv | 31 +++
 rtl/program_loader.sv | 126 ++++++++++++
 tb/tb_program_loader.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
// Host byte link plus cpumemory write port as seen by the program loader.
// The master modport is the loader; the slave modport is the host/memory side.
interface program_loader_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int WORD_SIZE  = 32
);
  logic                  byte_valid;
  logic [7:0]            byte_data;
  logic                  byte_ready;
  logic                  mem_write_en;
  logic [ADDR_WIDTH-1:0] mem_write_addr;
  logic [WORD_SIZE-1:0]  mem_write_data;

  modport master (
    input  byte_valid,
    input  byte_data,
    output byte_ready,
    output mem_write_en,
    output mem_write_addr,
    output mem_write_data
  );

  modport slave (
    output byte_valid,
    output byte_data,
    input  byte_ready,
    input  mem_write_en,
    input  mem_write_addr,
    input  mem_write_data
  );
endinterface

// File: rtl/program_loader.sv
// Packs a host byte stream (MSB first) into 32-bit words and writes them to consecutive
// instruction-memory addresses; write lands 1 cycle after the 4th byte, byte_ready drops for that cycle.
module program_loader #(
  parameter int WORD_SIZE  = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_WORDS  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   word_count,
  program_loader_if.master      bus,
  output logic                  cpu_rst,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH:0] MAX_N = (ADDR_WIDTH+1)'(NUM_WORDS);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   n_q, n_d;
  logic [ADDR_WIDTH:0]   words_q, words_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0]  pack_q, pack_d;
  logic [WORD_SIZE-1:0]  wdata_q, wdata_d;
  logic [1:0]            idx_q, idx_d;
  logic                  byte_ready_q;
  logic                  we_q;
  logic                  cpu_rst_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  accept;
  logic [ADDR_WIDTH:0]   n_clamped;

  assign accept    = bus.byte_valid & byte_ready_q;
  assign n_clamped = (word_count > MAX_N) ? MAX_N : word_count;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    words_d = words_q;
    addr_d  = addr_q;
    pack_d  = pack_q;
    wdata_d = wdata_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          n_d     = n_clamped;
          words_d = '0;
          addr_d  = '0;
          idx_d   = '0;
          state_d = (n_clamped == '0) ? DONE : RECV;
        end
      end
      RECV: begin
        if (accept) begin
          pack_d = {pack_q[WORD_SIZE-9:0], bus.byte_data};
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            wdata_d = pack_d;
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        words_d = words_q + (ADDR_WIDTH+1)'(1);
        // The address stays on the last written word so it never wraps past n-1.
        if (words_d == n_q) begin
          state_d = DONE;
        end else begin
          addr_d  = addr_q + ADDR_WIDTH'(1);
          state_d = RECV;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so each one matches the state it reports.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      n_q          <= '0;
      words_q      <= '0;
      addr_q       <= '0;
      pack_q       <= '0;
      wdata_q      <= '0;
      idx_q        <= '0;
      byte_ready_q <= 1'b0;
      we_q         <= 1'b0;
      cpu_rst_q    <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      words_q      <= words_d;
      addr_q       <= addr_d;
      pack_q       <= pack_d;
      wdata_q      <= wdata_d;
      idx_q        <= idx_d;
      byte_ready_q <= (state_d == RECV);
      we_q         <= (state_d == WRITE);
      cpu_rst_q    <= (state_d != DONE);
      busy_q       <= (state_d == RECV) || (state_d == WRITE);
      done_q       <= (state_d == DONE);
    end
  end

  assign bus.byte_ready     = byte_ready_q;
  assign bus.mem_write_en   = we_q;
  assign bus.mem_write_addr = addr_q;
  assign bus.mem_write_data = wdata_q;
  assign cpu_rst            = cpu_rst_q;
  assign busy               = busy_q;
  assign done               = done_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: drives and checks on the falling edge, logs memory writes.
module tb_program_loader;
  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [8:0] word_count;
  logic       cpu_rst, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  wr_addr[$];
  logic [31:0] wr_data[$];

  program_loader_if #(.ADDR_WIDTH(8), .WORD_SIZE(32)) bus ();

  program_loader #(.WORD_SIZE(32), .ADDR_WIDTH(8), .NUM_WORDS(256)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .word_count (word_count),
    .bus        (bus),
    .cpu_rst    (cpu_rst),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    if (bus.mem_write_en === 1'b1) begin
      wr_addr.push_back(bus.mem_write_addr);
      wr_data.push_back(bus.mem_write_data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit got = 1'b0;
    bus.byte_valid = 1'b0;
    cycles(gap);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    for (int t = 0; t < 50 && !got; t++) begin
      if (bus.byte_ready === 1'b1) got = 1'b1;
      @(negedge clk);
    end
    if (!got) chk("byte_timeout", 32'(got), 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int k = 3; k >= 0; k--) send_byte(w[8*k +: 8], gap);
  endtask

  task automatic pulse_start(input logic [8:0] wc);
    word_count = wc;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.byte_valid = 1'b0;
    cycles(2);
    rst = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      if (done === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    chk("wait_done", 32'(seen), 32'd1);
  endtask

  function automatic logic [31:0] pat(input int i);
    logic [7:0] b = i[7:0];
    return {b, ~b, 8'hA5, b ^ 8'h3C};
  endfunction

  initial begin
    int bad;
    rst = 1'b1; start = 1'b0; word_count = '0;
    bus.byte_valid = 1'b0; bus.byte_data = '0;
    cycles(3);
    chk("rst_byte_ready", 32'(bus.byte_ready), 32'd0);
    chk("rst_we",         32'(bus.mem_write_en), 32'd0);
    chk("rst_addr",       32'(bus.mem_write_addr), 32'd0);
    chk("rst_data",       bus.mem_write_data, 32'd0);
    chk("rst_cpu_rst",    32'(cpu_rst), 32'd1);
    chk("rst_busy",       32'(busy), 32'd0);
    chk("rst_done",       32'(done), 32'd0);
    rst = 1'b0;

    // 1: two words, valid held high
    pulse_start(9'd2);
    chk("t1_busy", 32'(busy), 32'd1);
    send_word(32'h8C010004, 0);
    send_word(32'hAC020008, 0);
    chk("t1_we_latency", 32'(bus.mem_write_en), 32'd1);
    chk("t1_ready_in_write", 32'(bus.byte_ready), 32'd0);
    chk("t1_cpu_rst_loading", 32'(cpu_rst), 32'd1);
    bus.byte_valid = 1'b0;
    @(negedge clk);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_cpu_rst", 32'(cpu_rst), 32'd0);
    chk("t1_nwrites", 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) begin
      chk("t1_addr0", 32'(wr_addr[0]), 32'd0);
      chk("t1_data0", wr_data[0], 32'h8C010004);
      chk("t1_addr1", 32'(wr_addr[1]), 32'd1);
      chk("t1_data1", wr_data[1], 32'hAC020008);
    end

    // 2: reload from DONE with 3-cycle gaps between bytes
    wr_addr.delete(); wr_data.delete();
    pulse_start(9'd2);
    chk("t2_cpu_rst_reload", 32'(cpu_rst), 32'd1);
    chk("t2_done_low", 32'(done), 32'd0);
    send_word(32'h8C010004, 3);
    send_word(32'hAC020008, 3);
    bus.byte_valid = 1'b0;
    wait_done();
    chk("t2_nwrites", 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) begin
      chk("t2_addr0", 32'(wr_addr[0]), 32'd0);
      chk("t2_data0", wr_data[0], 32'h8C010004);
      chk("t2_addr1", 32'(wr_addr[1]), 32'd1);
      chk("t2_data1", wr_data[1], 32'hAC020008);
    end

    // 3: zero-word load
    do_reset();
    wr_addr.delete(); wr_data.delete();
    pulse_start(9'd0);
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_cpu_rst", 32'(cpu_rst), 32'd0);
    chk("t3_busy", 32'(busy), 32'd0);
    cycles(3);
    chk("t3_nwrites", 32'(wr_addr.size()), 32'd0);

    // 4: count above depth is clamped to 256
    do_reset();
    wr_addr.delete(); wr_data.delete();
    pulse_start(9'd300);
    for (int i = 0; i < 256; i++) send_word(pat(i), 0);
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'hEE;
    wait_done();
    cycles(5);
    bus.byte_valid = 1'b0;
    chk("t4_nwrites", 32'(wr_addr.size()), 32'd256);
    bad = 0;
    for (int i = 0; i < wr_addr.size() && i < 256; i++)
      if (wr_addr[i] !== i[7:0] || wr_data[i] !== pat(i)) bad++;
    chk("t4_bad_words", 32'(bad), 32'd0);
    if (wr_addr.size() > 0) chk("t4_last_addr", 32'(wr_addr[wr_addr.size()-1]), 32'd255);
    chk("t4_cpu_rst", 32'(cpu_rst), 32'd0);

    // 5: reset mid-word, then a fresh single-word load
    do_reset();
    wr_addr.delete(); wr_data.delete();
    pulse_start(9'd2);
    send_byte(8'hDE, 0);
    send_byte(8'hAD, 0);
    bus.byte_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_ready", 32'(bus.byte_ready), 32'd0);
    chk("t5_we", 32'(bus.mem_write_en), 32'd0);
    pulse_start(9'd1);
    send_word(32'h11223344, 0);
    bus.byte_valid = 1'b0;
    wait_done();
    chk("t5_nwrites", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() == 1) begin
      chk("t5_addr0", 32'(wr_addr[0]), 32'd0);
      chk("t5_data0", wr_data[0], 32'h11223344);
    end

    // 6: start during RECV ignored; start in DONE reloads from addr 0
    do_reset();
    wr_addr.delete(); wr_data.delete();
    pulse_start(9'd2);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    bus.byte_valid = 1'b0;
    pulse_start(9'd5);
    chk("t6_busy_after_start", 32'(busy), 32'd1);
    send_byte(8'h03, 0);
    send_byte(8'h04, 0);
    send_word(32'h05060708, 0);
    bus.byte_valid = 1'b0;
    wait_done();
    chk("t6_nwrites", 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) begin
      chk("t6_data0", wr_data[0], 32'h01020304);
      chk("t6_data1", wr_data[1], 32'h05060708);
    end
    wr_addr.delete(); wr_data.delete();
    pulse_start(9'd1);
    chk("t6_reload_cpu_rst", 32'(cpu_rst), 32'd1);
    send_word(32'hCAFEF00D, 0);
    bus.byte_valid = 1'b0;
    wait_done();
    chk("t6_reload_nwrites", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() == 1) begin
      chk("t6_reload_addr", 32'(wr_addr[0]), 32'd0);
      chk("t6_reload_data", wr_data[0], 32'hCAFEF00D);
    end
    chk("t6_cpu_rst_run", 32'(cpu_rst), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
